// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, FSM states,
// ALU operation codes and datapath mux select codes.
package control_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10,
        S_JAL      = 4'd11,
        S_LUI      = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/multicycle_control_unit_mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready; expired flags the configured limit.
module mem_wait_timer #(
    parameter int TMR_W       = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (en)
            count <= count + TMR_W'(1);
    end

    assign expired = (count == TMR_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM over a shared req/ready memory.
// Define CU_PERF_CNT_EN to build the retired-instruction counter on instret.
module multicycle_control_unit
    import control_pkg::*;
#(
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 15,
    parameter int TMR_W       = 8,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [6:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               iord,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_write,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         result_src,
    output logic               illegal,
    output logic               mem_fault,
    output logic [3:0]         state_o,
    output logic [CNT_W-1:0]   instret
);

    state_t     state, next_state;
    logic       in_mem, expired, timeout, set_illegal;
    logic [1:0] alu_code;

    // The wait count restarts whenever a memory request completes or we leave the memory states.
    assign in_mem  = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign timeout = in_mem && !mem_ready && expired;

    mem_wait_timer #(
        .TMR_W       (TMR_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_mem || mem_ready),
        .en      (in_mem && !mem_ready),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            illegal   <= 1'b0;
            mem_fault <= 1'b0;
        end else begin
            state <= next_state;
            if (set_illegal)
                illegal <= 1'b1;
            if (timeout)
                mem_fault <= 1'b1;
        end
    end

    always_comb begin
        next_state  = state;
        set_illegal = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        alu_code    = ALU_ADD;
        result_src  = RES_ALUOUT;
        case (state)
            S_IDLE: if (run) next_state = S_FETCH;
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready)    next_state = S_DECODE;
                else if (timeout) next_state = S_TRAP;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECR;
                    OP_ITYPE:          next_state = S_EXECI;
                    OP_BRANCH:         next_state = S_BEQ;
                    OP_JAL:            next_state = S_JAL;
                    OP_LUI:            next_state = S_LUI;
                    default: begin
                        next_state  = S_TRAP;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                next_state = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready)    next_state = S_MEMWB;
                else if (timeout) next_state = S_TRAP;
            end
            S_MEMWB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready)    next_state = S_FETCH;
                else if (timeout) next_state = S_TRAP;
            end
            S_EXECR: begin
                alu_src_a  = SRCA_RS1;
                alu_code   = ALU_FUNCT;
                next_state = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                alu_code   = ALU_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_code   = ALU_SUB;
                pc_write   = zero;
                next_state = S_FETCH;
            end
            // JAL takes the precomputed target now and writes the return address via ALUWB.
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                pc_write   = 1'b1;
                next_state = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                next_state = S_ALUWB;
            end
            S_TRAP:  next_state = S_TRAP;
            default: next_state = S_IDLE;
        endcase
    end

    assign alu_op  = ALUOP_W'(alu_code);
    assign state_o = state;

`ifdef CU_PERF_CNT_EN
    logic [CNT_W-1:0] instret_q;
    logic             retire;

    assign retire = (next_state == S_FETCH) &&
                    ((state == S_MEMWB) || (state == S_MEMWRITE) ||
                     (state == S_ALUWB) || (state == S_BEQ));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            instret_q <= '0;
        else if (retire)
            instret_q <= instret_q + CNT_W'(1);
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit: table of zero-wait
// instructions plus hand sequences for wait states, timeout, reset and traps.
module tb_multicycle_control_unit;

    localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2, ST_MEMADR = 4'd3;
    localparam logic [3:0] ST_MEMREAD = 4'd4, ST_MEMWB = 4'd5, ST_MEMWRITE = 4'd6, ST_EXECR = 4'd7;
    localparam logic [3:0] ST_EXECI = 4'd8, ST_ALUWB = 4'd9, ST_BEQ = 4'd10, ST_JAL = 4'd11;
    localparam logic [3:0] ST_LUI = 4'd12, ST_TRAP = 4'd13;

    localparam logic [6:0] OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011, OPC_ADD = 7'b0110011;
    localparam logic [6:0] OPC_ADDI = 7'b0010011, OPC_BEQ = 7'b1100011, OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_BAD = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst, run, zero, mem_ready;
    logic [6:0]  opcode;
    logic        mem_req, mem_we, iord, ir_write, pc_write, reg_write, illegal, mem_fault;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
    logic [3:0]  state_o;
    logic [31:0] instret;

    int tests = 0;
    int fails = 0;
    int expRetired = 0;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic       z;
        int         len;
        logic [3:0] seq[5];
    } vec_t;

    vec_t vecs[$];

    multicycle_control_unit dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
        .illegal(illegal), .mem_fault(mem_fault), .state_o(state_o), .instret(instret)
    );

    always #5 clk = ~clk;

    // Expected control word per state, derived from the state-by-state output table.
    function automatic logic [13:0] expOut(logic [3:0] st, logic rdy, logic z);
        logic       req, we, io, irw, pcw, rw;
        logic [1:0] a, b, op, rs;
        {req, we, io, irw, pcw, rw} = 6'b0;
        {a, b, op, rs} = 8'b0;
        case (st)
            ST_FETCH:    begin req = 1'b1; irw = rdy; pcw = rdy; b = 2'b10; rs = 2'b10; end
            ST_DECODE:   begin a = 2'b01; b = 2'b01; end
            ST_MEMADR:   begin a = 2'b10; b = 2'b01; end
            ST_MEMREAD:  begin req = 1'b1; io = 1'b1; end
            ST_MEMWB:    begin rs = 2'b01; rw = 1'b1; end
            ST_MEMWRITE: begin req = 1'b1; we = 1'b1; io = 1'b1; end
            ST_EXECR:    begin a = 2'b10; op = 2'b10; end
            ST_EXECI:    begin a = 2'b10; b = 2'b01; op = 2'b10; end
            ST_ALUWB:    begin rw = 1'b1; end
            ST_BEQ:      begin a = 2'b10; op = 2'b01; pcw = z; end
            ST_JAL:      begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
            ST_LUI:      begin a = 2'b10; b = 2'b01; end
            default:     ;
        endcase
        return {req, we, io, irw, pcw, rw, a, b, op, rs};
    endfunction

    function automatic logic [31:0] expInstret();
`ifdef CU_PERF_CNT_EN
        return 32'(expRetired);
`else
        return 32'd0;
`endif
    endfunction

    task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(string name, logic [3:0] expSt);
        #1;
        checkVal({name, " state"}, 32'(state_o), 32'(expSt));
        checkVal({name, " ctrl"},
                 32'({mem_req, mem_we, iord, ir_write, pc_write, reg_write,
                      alu_src_a, alu_src_b, alu_op, result_src}),
                 32'(expOut(expSt, mem_ready, zero)));
    endtask

    task automatic applyStimulus(logic r, logic rdy, logic [6:0] op, logic z);
        run       = r;
        mem_ready = rdy;
        opcode    = op;
        zero      = z;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(string n, logic [6:0] op, logic z, int len,
                          logic [3:0] s0, logic [3:0] s1, logic [3:0] s2,
                          logic [3:0] s3, logic [3:0] s4);
        vec_t v;
        v.name = n; v.op = op; v.z = z; v.len = len;
        v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2; v.seq[3] = s3; v.seq[4] = s4;
        vecs.push_back(v);
    endtask

    task automatic restart();
        rst = 1'b1;
        #1;
        checkVal("reset state", 32'(state_o), 32'(ST_IDLE));
        checkVal("reset illegal", 32'(illegal), 32'd0);
        checkVal("reset mem_fault", 32'(mem_fault), 32'd0);
        checkVal("reset instret", instret, 32'd0);
        expRetired = 0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, OPC_ADD, 1'b0);
        tick();
        checkOutput("restart fetch", ST_FETCH);
        run = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        addVec("add",    OPC_ADD,   1'b0, 4, ST_FETCH, ST_DECODE, ST_EXECR,  ST_ALUWB,    ST_IDLE);
        addVec("addi",   OPC_ADDI,  1'b0, 4, ST_FETCH, ST_DECODE, ST_EXECI,  ST_ALUWB,    ST_IDLE);
        addVec("lui",    OPC_LUI,   1'b0, 4, ST_FETCH, ST_DECODE, ST_LUI,    ST_ALUWB,    ST_IDLE);
        addVec("jal",    OPC_JAL,   1'b0, 4, ST_FETCH, ST_DECODE, ST_JAL,    ST_ALUWB,    ST_IDLE);
        addVec("lw",     OPC_LOAD,  1'b0, 5, ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMREAD,  ST_MEMWB);
        addVec("sw",     OPC_STORE, 1'b0, 4, ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMWRITE, ST_IDLE);
        addVec("beq_z1", OPC_BEQ,   1'b1, 3, ST_FETCH, ST_DECODE, ST_BEQ,    ST_IDLE,     ST_IDLE);
        addVec("beq_z0", OPC_BEQ,   1'b0, 3, ST_FETCH, ST_DECODE, ST_BEQ,    ST_IDLE,     ST_IDLE);
        addVec("add2",   OPC_ADD,   1'b0, 4, ST_FETCH, ST_DECODE, ST_EXECR,  ST_ALUWB,    ST_IDLE);

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, OPC_ADD, 1'b0);
        repeat (2) @(posedge clk);
        checkOutput("reset idle", ST_IDLE);
        checkVal("reset illegal", 32'(illegal), 32'd0);
        checkVal("reset mem_fault", 32'(mem_fault), 32'd0);
        checkVal("reset instret", instret, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        checkOutput("idle without run", ST_IDLE);
        run = 1'b1;
        tick();
        checkOutput("run to fetch", ST_FETCH);
        run = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(1'b0, 1'b1, vecs[i].op, vecs[i].z);
            for (int c = 0; c < vecs[i].len; c++) begin
                checkOutput($sformatf("%s c%0d", vecs[i].name, c), vecs[i].seq[c]);
                tick();
            end
            expRetired++;
        end
        checkOutput("after table", ST_FETCH);
        checkVal("instret after table", instret, expInstret());

        // Load whose data phase waits three cycles on memory.
        applyStimulus(1'b0, 1'b1, OPC_LOAD, 1'b0);
        checkOutput("lw_wait fetch", ST_FETCH);
        tick();
        checkOutput("lw_wait decode", ST_DECODE);
        tick();
        checkOutput("lw_wait memadr", ST_MEMADR);
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("lw_wait memread w%0d", i), ST_MEMREAD);
            tick();
        end
        mem_ready = 1'b1;
        checkOutput("lw_wait memread done", ST_MEMREAD);
        tick();
        checkOutput("lw_wait memwb", ST_MEMWB);
        tick();
        checkOutput("lw_wait back", ST_FETCH);
        expRetired++;

        // Memory answers exactly at the timeout limit: no fault.
        applyStimulus(1'b0, 1'b0, OPC_ADD, 1'b0);
        for (int i = 0; i < 15; i++) begin
            checkOutput($sformatf("edge wait %0d", i), ST_FETCH);
            tick();
        end
        mem_ready = 1'b1;
        checkOutput("edge ready at limit", ST_FETCH);
        tick();
        checkOutput("edge decode", ST_DECODE);
        checkVal("edge no fault", 32'(mem_fault), 32'd0);
        tick();
        checkOutput("edge execr", ST_EXECR);
        tick();
        checkOutput("edge aluwb", ST_ALUWB);
        tick();
        checkOutput("edge back", ST_FETCH);
        expRetired++;
        checkVal("instret after edge", instret, expInstret());

        // Asynchronous reset in the middle of a stalled load.
        applyStimulus(1'b0, 1'b1, OPC_LOAD, 1'b0);
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        checkOutput("rst_mid memread", ST_MEMREAD);
        #2;
        rst = 1'b1;
        checkOutput("rst_mid idle", ST_IDLE);
        checkVal("rst_mid instret", instret, 32'd0);
        expRetired = 0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, OPC_ADD, 1'b0);
        tick();
        checkOutput("rst_mid refetch", ST_FETCH);
        run = 1'b0;

        // Memory never answers in FETCH: fault after the limit.
        mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("tmo wait %0d", i), ST_FETCH);
            tick();
        end
        checkOutput("tmo trap", ST_TRAP);
        checkVal("tmo mem_fault", 32'(mem_fault), 32'd1);
        checkVal("tmo illegal", 32'(illegal), 32'd0);
        for (int i = 0; i < 4; i++) begin
            run = i[0];
            mem_ready = 1'b1;
            tick();
            checkOutput($sformatf("tmo sticky %0d", i), ST_TRAP);
            checkVal("tmo fault sticky", 32'(mem_fault), 32'd1);
        end
        restart();

        // Unsupported opcode traps and stays trapped.
        applyStimulus(1'b0, 1'b1, OPC_BAD, 1'b0);
        tick();
        checkOutput("bad decode", ST_DECODE);
        tick();
        checkOutput("bad trap", ST_TRAP);
        checkVal("bad illegal", 32'(illegal), 32'd1);
        for (int i = 0; i < 4; i++) begin
            run = ~i[0];
            tick();
            checkOutput($sformatf("bad sticky %0d", i), ST_TRAP);
            checkVal("bad illegal sticky", 32'(illegal), 32'd1);
        end
        checkVal("bad no mem_fault", 32'(mem_fault), 32'd0);
        restart();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
